// File: rtl/fizzbuzz_text_ctrl_if.sv
// Pixel-side bundle between the video timing, the character generator and fizzbuzz_text_ctrl.
// FIZZBUZZ_KIND_TAG_EN adds the per-character kind tag.
interface fizzbuzz_text_ctrl_if;
    logic       frame_start;
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] char_code;
    logic [2:0] rownum;
    logic [7:0] glyph;
    logic       pix_on;
    logic       active_out;
`ifdef FIZZBUZZ_KIND_TAG_EN
    logic [1:0] kind;

    modport master (
        output frame_start, active, x, y, glyph,
        input  char_code, rownum, pix_on, active_out, kind
    );

    modport slave (
        input  frame_start, active, x, y, glyph,
        output char_code, rownum, pix_on, active_out, kind
    );
`else
    modport master (
        output frame_start, active, x, y, glyph,
        input  char_code, rownum, pix_on, active_out
    );

    modport slave (
        input  frame_start, active, x, y, glyph,
        output char_code, rownum, pix_on, active_out
    );
`endif
endinterface

// File: rtl/fizzbuzz_text_ctrl.sv
// FizzBuzz text overlay: one entry per 8-line text row, 8-slot field, two-stage pixel pipeline.
// Optional macro FIZZBUZZ_KIND_TAG_EN adds a pipelined kind output.
module fizzbuzz_text_ctrl #(
    parameter int MAX_NUM   = 100,
    parameter int FIELD_COL = 0,
    parameter int H_LAST    = 639
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fizzbuzz_text_ctrl_if.slave  bus
);

    localparam logic [3:0]  CH_B     = 4'd10;
    localparam logic [3:0]  CH_F     = 4'd11;
    localparam logic [3:0]  CH_I     = 4'd12;
    localparam logic [3:0]  CH_U     = 4'd13;
    localparam logic [3:0]  CH_Z     = 4'd14;
    localparam logic [3:0]  CH_BLANK = 4'd15;
    localparam logic [9:0]  H_LAST_X = 10'(H_LAST);
    localparam logic [6:0]  FC       = 7'(FIELD_COL);
    localparam logic [6:0]  FC_END   = 7'(FIELD_COL + 8);
    localparam logic [2:0]  FC_LO    = 3'(FIELD_COL);
    localparam logic [11:0] MAX_BCD  = {4'(MAX_NUM / 100), 4'((MAX_NUM / 10) % 10), 4'(MAX_NUM % 10)};

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state_reg;
    logic [2:0][3:0] bcd_reg;
    logic [2:0][3:0] bcd_next;
    logic [2:0]      carry;
    logic [1:0]      mod3_reg;
    logic [2:0]      mod5_reg;
    logic            over_reg;

    logic [3:0]      char_code_reg;
    logic [2:0]      rownum_reg;
    logic [2:0]      col_reg;
    logic            act1_reg;
    logic            pix_on_reg;
    logic            active_out_reg;

    logic [6:0]      x_col;
    logic            in_field;
    logic [2:0]      slot;
    logic            fizz;
    logic            buzz;
    logic            advance;
    logic            at_max;
    logic [3:0]      fizz_ch;
    logic [3:0]      buzz_ch;
    logic [3:0]      char_next;

    // BCD ripple increment: a digit steps when every lower digit is 9
    assign carry[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_bcd
            if (gi < 2) begin : g_carry
                assign carry[gi+1] = carry[gi] & (bcd_reg[gi] == 4'd9);
            end
            assign bcd_next[gi] = !carry[gi]            ? bcd_reg[gi] :
                                  (bcd_reg[gi] == 4'd9) ? 4'd0        :
                                                          bcd_reg[gi] + 4'd1;
        end
    endgenerate

    assign x_col    = bus.x[9:3];
    assign in_field = (x_col >= FC) && (x_col < FC_END);
    assign slot     = x_col[2:0] - FC_LO;
    assign fizz     = (mod3_reg == 2'd0);
    assign buzz     = (mod5_reg == 3'd0);
    assign at_max   = (bcd_reg == MAX_BCD);
    assign advance  = (state_reg == SCAN) && bus.active && (bus.x == H_LAST_X) && (bus.y[2:0] == 3'd7);

    always_comb begin
        fizz_ch = CH_Z;
        buzz_ch = CH_Z;
        case (slot[1:0])
            2'd0: begin fizz_ch = CH_F; buzz_ch = CH_B; end
            2'd1: begin fizz_ch = CH_I; buzz_ch = CH_U; end
            default: ;
        endcase
    end

    always_comb begin
        char_next = CH_BLANK;
        if ((state_reg == SCAN) && bus.active && in_field && !over_reg) begin
            if (fizz && buzz) begin
                char_next = slot[2] ? buzz_ch : fizz_ch;
            end else if (fizz) begin
                if (!slot[2]) char_next = fizz_ch;
            end else if (buzz) begin
                if (!slot[2]) char_next = buzz_ch;
            end else begin
                // left-justify: skip the leading zero digits
                case (slot)
                    3'd0: char_next = (bcd_reg[2] != 4'd0) ? bcd_reg[2] :
                                      (bcd_reg[1] != 4'd0) ? bcd_reg[1] : bcd_reg[0];
                    3'd1: char_next = (bcd_reg[2] != 4'd0) ? bcd_reg[1] :
                                      (bcd_reg[1] != 4'd0) ? bcd_reg[0] : CH_BLANK;
                    3'd2: char_next = (bcd_reg[2] != 4'd0) ? bcd_reg[0] : CH_BLANK;
                    default: char_next = CH_BLANK;
                endcase
            end
        end
    end

`ifdef FIZZBUZZ_KIND_TAG_EN
    logic [1:0] kind_next;
    logic [1:0] kind1_reg;
    logic [1:0] kind_reg;

    always_comb begin
        kind_next = 2'd0;
        if (char_next != CH_BLANK) begin
            if (fizz && buzz) kind_next = 2'd3;
            else if (fizz)    kind_next = 2'd1;
            else if (buzz)    kind_next = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kind1_reg <= 2'd0;
            kind_reg  <= 2'd0;
        end else begin
            kind1_reg <= kind_next;
            kind_reg  <= kind1_reg;
        end
    end

    assign bus.kind = kind_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            bcd_reg        <= {4'd0, 4'd0, 4'd1};
            mod3_reg       <= 2'd1;
            mod5_reg       <= 3'd1;
            over_reg       <= 1'b0;
            char_code_reg  <= CH_BLANK;
            rownum_reg     <= 3'd0;
            col_reg        <= 3'd0;
            act1_reg       <= 1'b0;
            pix_on_reg     <= 1'b0;
            active_out_reg <= 1'b0;
        end else begin
            char_code_reg  <= char_next;
            rownum_reg     <= bus.y[2:0];
            col_reg        <= bus.x[2:0];
            act1_reg       <= bus.active;
            pix_on_reg     <= bus.glyph[3'd7 - col_reg] & act1_reg;
            active_out_reg <= act1_reg;

            if (bus.frame_start) begin
                state_reg <= SCAN;
                bcd_reg   <= {4'd0, 4'd0, 4'd1};
                mod3_reg  <= 2'd1;
                mod5_reg  <= 3'd1;
                over_reg  <= 1'b0;
            end else if (advance && !over_reg) begin
                // stepping past MAX_NUM only raises the flag, so the count never wraps
                if (at_max) begin
                    over_reg <= 1'b1;
                end else begin
                    bcd_reg  <= bcd_next;
                    mod3_reg <= (mod3_reg == 2'd2) ? 2'd0 : mod3_reg + 2'd1;
                    mod5_reg <= (mod5_reg == 3'd4) ? 3'd0 : mod5_reg + 3'd1;
                end
            end
        end
    end

    assign bus.char_code  = char_code_reg;
    assign bus.rownum     = rownum_reg;
    assign bus.pix_on     = pix_on_reg;
    assign bus.active_out = active_out_reg;

endmodule

// File: tb/tb_fizzbuzz_text_ctrl.sv
// Scoreboard bench for fizzbuzz_text_ctrl: randomized scanlines against a string-level FizzBuzz model.
// Build with FIZZBUZZ_KIND_TAG_EN to also check the kind output.
module tb_fizzbuzz_text_ctrl;

    localparam int MAX_NUM   = 100;
    localparam int FIELD_COL = 0;
    localparam int H_LAST    = 639;

    typedef struct packed {
        logic       rst;
        logic [3:0] ch;
        logic [2:0] rn;
        logic       pix;
        logic       act;
        logic [1:0] kind;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fizzbuzz_text_ctrl_if bus();

    fizzbuzz_text_ctrl #(
        .MAX_NUM   (MAX_NUM),
        .FIELD_COL (FIELD_COL),
        .H_LAST    (H_LAST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // character generator stand-in: random font, blank glyph all zero
    logic [7:0] font [16][8];
    assign bus.glyph = font[bus.char_code][bus.rownum];

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   m_scan = 0;
    int   m_n = 1;

    task automatic chk(string name, logic [7:0] got, logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic int exp_char(int n, bit scan, bit act, int xv);
        int    fb[8] = '{11, 12, 14, 14, 10, 13, 14, 14};
        int    col;
        int    s;
        string str;
        if (!scan || !act) return 15;
        col = xv / 8;
        if (col < FIELD_COL || col >= FIELD_COL + 8) return 15;
        s = col - FIELD_COL;
        if (n > MAX_NUM) return 15;
        if (n % 15 == 0) return fb[s];
        if (n % 3 == 0) return (s < 4) ? fb[s] : 15;
        if (n % 5 == 0) return (s < 4) ? fb[s + 4] : 15;
        str = $sformatf("%0d", n);
        if (s < str.len()) return int'(str[s]) - 48;
        return 15;
    endfunction

    function automatic int exp_kind(int n, int ch);
        if (ch == 15) return 0;
        if (n % 15 == 0) return 3;
        if (n % 3 == 0) return 1;
        if (n % 5 == 0) return 2;
        return 0;
    endfunction

    task automatic cyc(bit rstn, bit fs, bit act, int xv, int yv);
        exp_t e;
        int   ch;
        @(negedge clk);
        rst_n           = rstn;
        bus.frame_start = fs;
        bus.active      = act;
        bus.x           = 10'(xv);
        bus.y           = 10'(yv);
        if (!rstn) begin
            e.rst = 1'b1; e.ch = 4'd15; e.rn = 3'd0; e.pix = 1'b0; e.act = 1'b0; e.kind = 2'd0;
            m_scan = 0;
            m_n    = 1;
        end else begin
            ch     = exp_char(m_n, m_scan, act, xv);
            e.rst  = 1'b0;
            e.ch   = 4'(ch);
            e.rn   = 3'(yv % 8);
            e.pix  = act && font[ch][yv % 8][7 - (xv % 8)];
            e.act  = act;
            e.kind = 2'(exp_kind(m_n, ch));
            if (fs) begin
                m_scan = 1;
                m_n    = 1;
            end else if (m_scan && act && xv == H_LAST && yv % 8 == 7 && m_n <= MAX_NUM) begin
                m_n++;
            end
        end
        q.push_back(e);
    endtask

    task automatic do_line(int yv, bit full, bit fs_end, bit rst_mid);
        int ns;
        int xv;
        bit act;
        ns = full ? (FIELD_COL + 12) * 8 : 12;
        for (int k = 0; k < ns; k++) begin
            if (full) begin
                xv  = k;
                act = 1;
            end else begin
                xv  = ($urandom % 4 != 0) ? int'($urandom_range(0, (FIELD_COL + 9) * 8 - 1))
                                          : int'($urandom_range(0, H_LAST - 1));
                act = ($urandom % 8 != 0);
            end
            cyc(!(rst_mid && k == ns / 2), 0, act, xv, yv);
        end
        cyc(1, fs_end, 1, H_LAST, yv);
        cyc(1, 0, 0, int'($urandom_range(H_LAST + 1, 799)), yv);
    endtask

    task automatic do_row(int r, bit full, bit fs_last, int rst_line);
        for (int l = 0; l < 8; l++)
            do_line(r * 8 + l, full, fs_last && l == 7, rst_line == l);
        $display("[TB] row %0d scanned, model n=%0d, checks so far %0d", r, m_n, tests);
    endtask

    // monitor: stage-1 outputs belong to the newest entry, stage-2 to the one before
    initial begin
        exp_t e;
        exp_t prev;
        bit   prev_v = 0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.rst) begin
                    chk("pix_on_reset", 8'(bus.pix_on), 8'd0);
                    chk("active_out_reset", 8'(bus.active_out), 8'd0);
`ifdef FIZZBUZZ_KIND_TAG_EN
                    chk("kind_reset", 8'(bus.kind), 8'd0);
`endif
                end else if (prev_v) begin
                    chk("pix_on", 8'(bus.pix_on), 8'(prev.pix));
                    chk("active_out", 8'(bus.active_out), 8'(prev.act));
`ifdef FIZZBUZZ_KIND_TAG_EN
                    chk("kind", 8'(bus.kind), 8'(prev.kind));
`endif
                end
                chk("char_code", 8'(bus.char_code), 8'(e.ch));
                chk("rownum", 8'(bus.rownum), 8'(e.rn));
                prev   = e;
                prev_v = 1;
            end
        end
    end

    initial begin
        int waited;
        for (int c = 0; c < 16; c++)
            for (int r = 0; r < 8; r++)
                font[c][r] = (c == 15) ? 8'h00 : 8'($urandom);
        bus.frame_start = 1'b0;
        bus.active      = 1'b0;
        bus.x           = '0;
        bus.y           = '0;

        repeat (3) cyc(0, 0, 0, 0, 0);
        // no frame_start yet: everything must stay blank
        do_row(0, 1, 0, -1);
        do_row(1, 0, 0, -1);

        // full frame, running past MAX_NUM into saturation
        cyc(1, 1, 0, 700, 0);
        for (int r = 0; r <= 110; r++)
            do_row(r, (r < 3 || r == 4 || r == 14 || r == 99 || r == 100), 0, -1);

        // frame_start coincident with the row-advance cycle, then a mid-line reset at row 20
        cyc(1, 1, 0, 700, 0);
        do_row(0, 0, 1, -1);
        for (int r = 1; r <= 22; r++)
            do_row(r, (r == 1 || r == 21), 0, (r == 20) ? 3 : -1);

        cyc(1, 1, 0, 700, 0);
        for (int r = 0; r <= 15; r++)
            do_row(r, (r == 0 || r == 2 || r == 4 || r == 14), 0, -1);

        repeat (3) cyc(1, 0, 0, 0, 0);
        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        chk("scoreboard_drain", 8'(q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fizzbuzz_text_ctrl.md
FIZZBUZZ_TEXT_CTRL -- requirements
Module: fizzbuzz_text_ctrl

Interface
REQ-001 Parameter MAX_NUM, default 100, last number displayed per frame (legal 1..999).
REQ-002 Parameter FIELD_COL, default 0, first character column of the 8-slot text field (legal 0..72).
REQ-003 Parameter H_LAST, default 639, last active x coordinate of a scanline.
REQ-004 clk  input  1  pixel clock; all state changes on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 frame_start  input  1  one-cycle pulse at the start of each frame, before the first active pixel.
REQ-007 active  input  1  current (x,y) is in the visible area.
REQ-008 x  input  10  current pixel column.
REQ-009 y  input  10  current pixel row.
REQ-010 char_code  output  4  glyph code to the character generator: 0-9 digits, 10 B, 11 F, 12 i, 13 u, 14 z, 15 blank.
REQ-011 rownum  output  3  glyph row to the character generator.
REQ-012 glyph  input  8  character generator row bits; bit 7 is the leftmost pixel; combinational from char_code/rownum.
REQ-013 pix_on  output  1  foreground pixel for the (x,y) presented two cycles earlier.
REQ-014 active_out  output  1  active delayed by two cycles, aligned with pix_on.

Function
REQ-015 Text row r = y[9:3] shows entry n = r+1; n is held as a 3-digit BCD count plus mod-3 and mod-5 counters, none computed by division.
REQ-016 Slot s = x[9:3] - FIELD_COL, valid for 0..7; outside the field, char_code = 15.
REQ-017 n mod 15 = 0 -> slots 0..7 = F i z z B u z z.
REQ-018 n mod 3 = 0 only -> slots 0..3 = F i z z; slots 4..7 blank.
REQ-019 n mod 5 = 0 only -> slots 0..3 = B u z z; slots 4..7 blank.
REQ-020 Otherwise, decimal digits are left-justified from slot 0 with leading zeros suppressed (7 -> "7", 42 -> "42", 100 -> "100"); remaining slots blank.
REQ-021 n > MAX_NUM -> all slots blank; the count saturates and does not wrap.
REQ-022 Stage 1 (cycle t+1): register char_code, rownum = y[2:0] and column x[2:0] from inputs sampled at t.
REQ-023 Stage 2 (cycle t+2): pix_on = glyph[7 - column] AND stage-1 active; active_out = stage-1 active.
REQ-024 Advance n (BCD +1 with carry 9->0, mod counters +1 with wrap 2->0 and 4->0) in the cycle with active=1, x=H_LAST and y[2:0]=7.
REQ-025 The advance updates state one cycle after x=H_LAST; slot outputs for that row are already registered, so there is no same-row corruption.
REQ-026 frame_start sets n=1 (BCD 001, mod3=1, mod5=1).
REQ-027 frame_start coincident with an advance condition: frame_start wins and n = 1.
REQ-028 active=0 -> char_code = 15 in stage 1; pix_on = 0 in stage 2.
REQ-029 The state machine is two-state, IDLE and SCAN: reset -> IDLE; frame_start -> SCAN; advances occur only in SCAN.

Reset
REQ-030 rst_n=0 at a clock edge -> char_code=15, rownum=0, pix_on=0, active_out=0, n=1, pipeline cleared, state IDLE.
REQ-031 Reset mid-frame discards the frame; output stays blank until the next frame_start.

Configuration
REQ-032 Macro FIZZBUZZ_KIND_TAG_EN defined -> extra output kind[1:0] (0 number, 1 Fizz, 2 Buzz, 3 FizzBuzz), pipelined to align with pix_on; reset value 0; 0 while blank or n > MAX_NUM.
REQ-033 Macro undefined -> no kind port and no associated logic; all other behaviour is identical.

Verification
REQ-034 frame_start, then row y=0..7, x=0..63 -> char_code sequence is 1,15,15,15,15,15,15,15 per 8 pixels; pix_on matches the "1" glyph rows with 2-cycle latency.
REQ-035 Rows 2, 4 and 14 (n=3, 5, 15) -> codes F i z z 15 15 15 15 / B u z z 15 15 15 15 / F i z z B u z z.
REQ-036 MAX_NUM=100, 480-line frames scanned into row 99 via scaled y -> n=100 shows 1,0,0; n=101 all 15, pix_on=0.
REQ-037 frame_start asserted on the cycle with x=639, y=7 -> next row shows n=1, not n=2.
REQ-038 rst_n low for one cycle at row 20 mid-line -> outputs reset values next cycle; blank until frame_start; then n=1.
REQ-039 FIELD_COL=10 -> x=80..87 carries slot 0; x=72 gives char_code 15; with FIZZBUZZ_KIND_TAG_EN, kind=3 on row 14.
